// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared opcode constants, FSM state encoding and immediate-opcode decode
package ifetch_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MV  = 3'b010;
    localparam logic [2:0] OP_MVI = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_JGE = 3'b110;
    localparam logic [2:0] OP_JLE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_I    = 3'd2,
        S_FETCH_IMM = 3'd3,
        S_WAIT_M    = 3'd4,
        S_EXEC      = 3'd5
    } state_t;

    function automatic logic has_imm(input logic [2:0] op);
        return (op == OP_MVI) || (op == OP_JMP) || (op == OP_JGE) || (op == OP_JLE);
    endfunction
endpackage

// File: rtl/ifetch_pc.sv
// ifetch_pc: program counter with load-over-increment priority, wraps modulo 2^AW
module ifetch_pc #(
    parameter int             AW       = 8,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          Resetn,
    input  logic          inc,
    input  logic          ld,
    input  logic [AW-1:0] ld_val,
    output logic [AW-1:0] pc
);
    logic [AW-1:0] pc_q, pc_d;

    // next pc: jump target wins over the increment
    always_comb pc_d = ld ? ld_val : (inc ? pc_q + AW'(1) : pc_q);

    // pc register
    always_ff @(posedge clk)
        if (!Resetn) pc_q <= RESET_PC;
        else         pc_q <= pc_d;

    assign pc = pc_q;
endmodule

// File: rtl/ifetch_seq.sv
// ifetch_seq: instruction fetch sequencer feeding ir/imm to the control unit
module ifetch_seq
    import ifetch_pkg::*;
#(
    parameter int             AW       = 8,
    parameter int             IW       = 9,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          Resetn,
    input  logic          en,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [IW-1:0] mem_rdata,
    output logic [IW-1:0] ir,
    output logic [IW-1:0] imm,
    output logic          Run,
    input  logic          done,
    input  logic          jmp,
    output logic [AW-1:0] pc
);
    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d, imm_q, imm_d;
    logic          run_q, run_d;
    logic          pc_inc, pc_ld;

    ifetch_pc #(.AW(AW), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .Resetn (Resetn),
        .inc    (pc_inc),
        .ld     (pc_ld),
        .ld_val (imm_q[AW-1:0]),
        .pc     (pc)
    );

    // sequencing: fetch word, optional immediate, then hold Run until done
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        case (state_q)
            S_IDLE:      state_d = en ? S_FETCH : S_IDLE;
            S_FETCH:     state_d = S_WAIT_I;
            S_WAIT_I: begin
                ir_d    = mem_rdata;
                pc_inc  = 1'b1;
                state_d = has_imm(mem_rdata[IW-1 -: 3]) ? S_FETCH_IMM : S_EXEC;
            end
            S_FETCH_IMM: state_d = S_WAIT_M;
            S_WAIT_M: begin
                imm_d   = mem_rdata;
                pc_inc  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_ld   = done & jmp;
                state_d = done ? (en ? S_FETCH : S_IDLE) : S_EXEC;
            end
            default:     state_d = S_IDLE;
        endcase
        run_d = (state_d == S_EXEC);
    end

    // state, instruction/immediate and registered Run
    always_ff @(posedge clk)
        if (!Resetn) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            imm_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            run_q   <= run_d;
        end

    assign mem_rd   = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
    assign mem_addr = pc;
    assign ir       = ir_q;
    assign imm      = imm_q;
    assign Run      = run_q;
endmodule

// File: tb/tb_ifetch_seq.sv
// tb_ifetch_seq: directed and randomized instruction-level checks of ifetch_seq
module tb_ifetch_seq;
    logic       clk = 1'b0, Resetn = 1'b0, en = 1'b0, done = 1'b0, jmp = 1'b0;
    logic       mem_rd, Run;
    logic [7:0] mem_addr, pc;
    logic [8:0] mem_rdata = '0, ir, imm;
    logic [8:0] mem [256];
    int         checks = 0, errors = 0;
    logic [7:0] m_pc;
    logic [8:0] m_imm;
    bit         chain;

    always #5 clk = ~clk;

    ifetch_seq #(.AW(8), .IW(9), .RESET_PC(8'hFF)) dut (
        .clk       (clk),
        .Resetn    (Resetn),
        .en        (en),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .imm       (imm),
        .Run       (Run),
        .done      (done),
        .jmp       (jmp),
        .pc        (pc)
    );

    // synchronous program memory; garbage when not read so stale use shows up
    always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 9'($urandom);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit imm_op(input logic [8:0] w);
        return w[8:6] inside {3'b011, 3'b100, 3'b110, 3'b111};
    endfunction

    task automatic do_reset();
        Resetn = 1'b0; en = 1'b0; done = 1'b0; jmp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_run", Run, 0);
        chk("rst_pc", pc, 8'hFF);
        chk("rst_ir", ir, 0);
        chk("rst_imm", imm, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 8'hFF);
        Resetn = 1'b1;
        m_pc = 8'hFF; m_imm = '0; chain = 0;
    endtask

    task automatic do_instr(input int dly, input bit jv, input bit drop, input bit rst_mid);
        logic [8:0] e_ir;
        logic [7:0] a0, a1;
        logic [7:0] rd[$];
        bit         hi;
        int         n;
        a0 = m_pc; a1 = a0 + 8'd1;
        e_ir = mem[a0]; hi = imm_op(e_ir);
        m_pc = a1;
        if (hi) begin m_imm = mem[a1]; m_pc = a1 + 8'd1; end
        en = 1'b1; n = 0;
        while (!Run && n < 20) begin
            if (mem_rd) rd.push_back(mem_addr);
            if (drop && rd.size() == 1 && !mem_rd) en = 1'b0;
            done = 1'($urandom); jmp = 1'($urandom);
            @(negedge clk); n++;
        end
        done = 1'b0; jmp = 1'b0;
        chk("run_rise", Run, 1);
        if (chain) chk("latency", n + 1, hi ? 5 : 3);
        chk("ir", ir, e_ir);
        chk("imm", imm, m_imm);
        chk("pc_exec", pc, m_pc);
        chk("nreads", rd.size(), hi ? 2 : 1);
        if (rd.size() > 0) chk("rd_addr0", rd[0], a0);
        if (hi && rd.size() > 1) chk("rd_addr1", rd[1], a1);
        if (rst_mid) begin
            Resetn = 1'b0;
            @(negedge clk);
            chk("mid_rst_run", Run, 0);
            chk("mid_rst_pc", pc, 8'hFF);
            chk("mid_rst_ir", ir, 0);
            Resetn = 1'b1;
            m_pc = 8'hFF; m_imm = '0; chain = 0;
            return;
        end
        repeat (dly) begin
            jmp = 1'($urandom);
            @(negedge clk);
            chk("run_hold", Run, 1);
            chk("ir_hold", ir, e_ir);
        end
        done = 1'b1; jmp = jv;
        @(negedge clk);
        done = 1'b0; jmp = 1'b0;
        if (jv) m_pc = m_imm[7:0];
        chk("run_fall", Run, 0);
        chk("pc_after", pc, m_pc);
        chk("next_addr", mem_addr, m_pc);
        chk("next_rd", mem_rd, en);
        chain = en;
        if (!en) repeat (2) begin
            @(negedge clk);
            chk("idle_rd", mem_rd, 0);
            chk("idle_pc", pc, m_pc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'hFF] = 9'h00A;
        mem[8'h00] = 9'h00A;
        mem[8'h01] = 9'h0D0;
        mem[8'h02] = 9'h05A;
        mem[8'h03] = 9'h100;
        mem[8'h04] = 9'h010;
        mem[8'h10] = 9'h180;
        mem[8'h11] = 9'h0FE;
        mem[8'h12] = 9'h100;
        mem[8'h13] = 9'h0FE;
        mem[8'hFE] = 9'h0D0;
        do_reset();
        do_instr(0, 0, 0, 0);
        do_instr(0, 0, 0, 0);
        do_instr(0, 0, 0, 0);
        do_instr(1, 1, 0, 0);
        do_instr(0, 0, 0, 0);
        do_instr(0, 1, 0, 0);
        do_instr(0, 0, 0, 0);
        do_instr(0, 0, 1, 0);
        do_instr(0, 0, 0, 1);
        for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
        do_reset();
        for (int k = 0; k < 200; k++)
            do_instr($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 7) == 0,
                     $urandom_range(0, 15) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
